// File: rtl/uart_rx.sv
// UART receiver for 8N1/8O1/8E1 frames with mid-bit sampling and parity/framing status.
// Optional RX_MAJORITY_EN: each sample is a 2-of-3 vote over mid-1, mid and mid+1.
//
// state  | meaning
// IDLE   | waiting for a high-to-low edge on the synchronised line
// START  | counting to mid start bit, rejecting false starts
// DATA   | sampling 8 data bits, LSB first
// PARITY | sampling the parity bit (odd/even frames only)
// STOP   | sampling the stop bit, then publishing byte and flags
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [1:0] parity_type,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
`ifdef RX_MAJORITY_EN
    // one extra cycle so the vote window mid-1..mid+1 is complete when used
    localparam logic [CW-1:0] START_LOAD = CW'(CLKS_PER_BIT / 2);
`else
    localparam logic [CW-1:0] START_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
`endif

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [1:0]             rst_sync;
    logic                   rst_n_int;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_s_d;
    logic                   sample_bit;
    logic [2:0]             state;
    logic [CW-1:0]          cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift_q;
    logic [1:0]             par_type_q;
    logic                   par_bit;
    logic                   par_en;
    logic                   par_odd;
    logic                   tick;

    // reset asserts immediately, releases on a clock edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            sync_q <= '1;
            rx_s_d <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_s_d <= rx_s;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef RX_MAJORITY_EN
    logic rx_s_d2;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            rx_s_d2 <= 1'b1;
        end else begin
            rx_s_d2 <= rx_s_d;
        end
    end

    assign sample_bit = (rx_s & rx_s_d) | (rx_s & rx_s_d2) | (rx_s_d & rx_s_d2);
`else
    assign sample_bit = rx_s;
`endif

    assign tick    = (cnt == '0);
    assign par_en  = par_type_q[0] ^ par_type_q[1];
    assign par_odd = (par_type_q == 2'b01);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift_q       <= '0;
            par_type_q    <= '0;
            par_bit       <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // a held-low line never looks like an edge, so breaks do not retrigger
                    if (rx_s_d && !rx_s) begin
                        par_type_q <= parity_type;
                        bit_idx    <= '0;
                        cnt        <= START_LOAD;
                        state      <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        cnt   <= FULL_LOAD;
                        state <= sample_bit ? IDLE : DATA;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt     <= FULL_LOAD;
                        shift_q <= {sample_bit, shift_q[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= par_en ? PARITY : STOP;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                PARITY: begin
                    if (tick) begin
                        cnt     <= FULL_LOAD;
                        par_bit <= sample_bit;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                STOP: begin
                    // publish at mid-stop so a back-to-back start edge is not missed
                    if (tick) begin
                        cnt           <= '0;
                        data_out      <= shift_q;
                        framing_error <= !sample_bit;
                        parity_error  <= par_en && ((^shift_q ^ par_bit) != par_odd);
                        data_valid    <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level model predicts byte, flags and the cycle of each data_valid.
// Build with RX_MAJORITY_EN defined to add the glitch-rejection case.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int HALF = CPB / 2;
`ifdef RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [1:0] parity_type = 2'b00;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .parity_type  (parity_type),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] last_data = 8'h00;
    logic       last_perr = 1'b0;
    logic       last_ferr = 1'b0;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_valid = 0;
    bit         chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Frame-level model: expected data_valid cycle is start drive + sync/detect latency
    // + half a bit + one bit per remaining frame bit up to the stop bit.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (data_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", data_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("valid_cycle", cyc, e.cyc);
                    check("frame_data", data_out, e.data);
                    check("frame_perr", parity_error, e.perr);
                    check("frame_ferr", framing_error, e.ferr);
                    last_data = e.data;
                    last_perr = e.perr;
                    last_ferr = e.ferr;
                end
                check("busy_at_valid", busy, 0);
            end else begin
                if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                    check("missing_valid", data_valid, 1);
                    void'(exp_q.pop_front());
                end
                check("hold_data", data_out, last_data);
                check("hold_perr", parity_error, last_perr);
                check("hold_ferr", framing_error, last_ferr);
            end
        end
    end

    // Called at a negedge; leaves rx at the stop level.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic pbit,
                              input logic stop, input bit toggle_pt, input int glitch_bit);
        exp_t e;
        logic pen;
        int   c0;
        pen = (pt == 2'b01) || (pt == 2'b10);
        c0 = cyc;
        parity_type = pt;
        e.data = d;
        e.ferr = !stop;
        e.perr = pen ? ((^d ^ pbit) != (pt == 2'b01)) : 1'b0;
        e.cyc  = c0 + SYNC + 1 + HALF + (pen ? 10 : 9) * CPB + MAJ;
        exp_q.push_back(e);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (toggle_pt && i == 3) parity_type = ~pt;
            if (i == glitch_bit) begin
                repeat (HALF) @(negedge clk);
                rx = ~d[i];
                @(negedge clk);
                rx = d[i];
                repeat (CPB - HALF - 1) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        if (pen) begin
            rx = pbit;
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        int  nv;
        bit  saw;
        logic [7:0] rd;

        repeat (3) @(negedge clk);
        check("reset_data_out", data_out, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_valid", data_valid, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_flags", {parity_error, framing_error}, 2'b00);
        chk_en = 1'b1;

        // basic 8N1
        send_frame(8'hA5, 2'b00, 1'b0, 1'b1, 1'b0, -1);
        repeat (4) @(negedge clk);
        check("t1_data", data_out, 8'hA5);
        check("t1_flags", {parity_error, framing_error}, 2'b00);
        check("t1_busy", busy, 0);

        // parity
        send_frame(8'h03, 2'b10, 1'b0, 1'b1, 1'b0, -1);
        repeat (4) @(negedge clk);
        check("t2_even_ok", parity_error, 0);
        send_frame(8'h03, 2'b10, 1'b1, 1'b1, 1'b0, -1);
        repeat (4) @(negedge clk);
        check("t2_even_err", parity_error, 1);
        send_frame(8'h03, 2'b01, 1'b1, 1'b1, 1'b0, -1);
        repeat (4) @(negedge clk);
        check("t2_odd_ok", parity_error, 0);

        // framing error followed by a long break
        nv = n_valid;
        send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b0, -1);
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("t3_data", data_out, 8'h5A);
        check("t3_ferr", framing_error, 1);
        check("t3_frames", n_valid, nv + 1);

        // false start
        nv = n_valid;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) saw = 1'b1;
        end
        check("t4_busy_seen", saw, 1);
        check("t4_busy_low", busy, 0);
        repeat (40) @(negedge clk);
        check("t4_no_valid", n_valid, nv);
        check("t4_ferr_held", framing_error, 1);
        check("t4_data_held", data_out, 8'h5A);

        // back-to-back, parity_type toggled mid-frame
        nv = n_valid;
        send_frame(8'h00, 2'b10, 1'b0, 1'b1, 1'b1, -1);
        send_frame(8'hFF, 2'b10, 1'b0, 1'b1, 1'b0, -1);
        repeat (4) @(negedge clk);
        check("t5_data", data_out, 8'hFF);
        check("t5_perr", parity_error, 0);
        check("t5_frames", n_valid, nv + 2);

        // reset in the middle of bit 4
        nv = n_valid;
        rd = 8'h96;
        parity_type = 2'b00;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = rd[i];
            repeat (CPB) @(negedge clk);
        end
        rx = rd[4];
        repeat (HALF) @(negedge clk);
        check("t6_busy_before", busy, 1);
        #2;
        last_data = 8'h00;
        last_perr = 1'b0;
        last_ferr = 1'b0;
        rst = 1'b0;
        #1;
        check("t6_async_data", data_out, 8'h00);
        check("t6_async_misc", {data_valid, parity_error, framing_error, busy}, 4'b0000);
        repeat (3) @(negedge clk);
        rx = 1'b1;
        rst = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("t6_no_valid", n_valid, nv);

        // recovery after reset
        send_frame(8'h3C, 2'b01, 1'b1, 1'b1, 1'b0, -1);
        repeat (4) @(negedge clk);
        check("t7_data", data_out, 8'h3C);
        check("t7_perr", parity_error, 0);

`ifdef RX_MAJORITY_EN
        send_frame(8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 2);
        repeat (4) @(negedge clk);
        check("t8_glitch_data", data_out, 8'h00);
`endif

        repeat (20) @(negedge clk);
        check("pending_frames", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
